// File: rtl/cdc_mailbox_ctrl.sv
// Saturn-CDC <-> STM32 mailbox: CR/RESP registers, HIRQ/mask, command FSM and STM32 interrupt block.
// Defining CDC_MBX_TIMEOUT_EN adds the command timeout counter, its reload register and pend[2].
module cdc_mailbox_ctrl #(
    parameter int          NUM_CR   = 4,
    parameter int          DW       = 16,
    parameter int          NUM_IRQ  = 6,
    parameter int          TMO_W    = 24,
    parameter logic [DW-1:0] HIRQ_RST = DW'(16'h0001)
) (
    input  logic               avm_clk,
    input  logic               NRESET,
    input  logic               ss_wr_start,
    input  logic               ss_rd_start,
    input  logic               ss_cs,
    input  logic [3:0]         ss_idx,
    input  logic [DW-1:0]      ss_din,
    output logic [DW-1:0]      ss_dout,
    output logic               ss_irq,
    input  logic               st_wr_start,
    input  logic [4:0]         st_idx,
    input  logic [DW-1:0]      st_din,
    output logic [DW-1:0]      st_dout,
    output logic               st_irq,
    input  logic [NUM_IRQ-4:0] ext_irq,
    output logic               busy
);

    localparam int         CRI_W     = (NUM_CR > 1) ? $clog2(NUM_CR) : 1;
    localparam logic [3:0] SS_COMMIT = 4'(2 + NUM_CR - 1);
    localparam logic [4:0] ST_COMMIT = 5'(8 + NUM_CR - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      hirq_q, hirq_d;
    logic [DW-1:0]      mask_q, mask_d;
    logic [DW-1:0]      cr_q   [NUM_CR];
    logic [DW-1:0]      cr_d   [NUM_CR];
    logic [DW-1:0]      resp_q [NUM_CR];
    logic [DW-1:0]      resp_d [NUM_CR];
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [DW-1:0]      ss_dout_q, ss_dout_d;
    logic [DW-1:0]      st_dout_q, st_dout_d;

    logic               ss_wr, ss_rd, ss_in_cr, st_in_cr;
    logic [3:0]         ss_cr_off;
    logic [4:0]         st_cr_off;
    logic               ss_commit, ss_resp_rd, st_commit, st_ack0, active;
    logic               tmo_hit;
    logic [DW-1:0]      rld_val;
    logic [DW-1:0]      ss_and, st_clr, st_set, status;
    logic [NUM_IRQ-1:0] pend_set, pend_clr;

    always_comb begin
        ss_wr      = ss_wr_start & ss_cs;
        ss_rd      = ss_rd_start & ss_cs;
        ss_cr_off  = ss_idx - 4'd2;
        st_cr_off  = st_idx - 5'd8;
        ss_in_cr   = (ss_idx >= 4'd2) && (ss_cr_off < 4'(NUM_CR));
        st_in_cr   = (st_idx >= 5'd8) && (st_cr_off < 5'(NUM_CR));
        ss_commit  = ss_wr && (ss_idx == SS_COMMIT);
        ss_resp_rd = ss_rd && (ss_idx == SS_COMMIT);
        st_commit  = st_wr_start && (st_idx == ST_COMMIT);
        st_ack0    = st_wr_start && (st_idx == 5'd2) && st_din[0];
        active     = (state_q != S_IDLE);
    end

`ifdef CDC_MBX_TIMEOUT_EN
    logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [DW-1:0]    rld_q, rld_d;

    // The hit is detected on the increment so pend[2] lands exactly reload cycles after PEND entry.
    always_comb begin
        rld_d = rld_q;
        if (st_wr_start && (st_idx == 5'd5)) begin
            rld_d = st_din;
        end
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        tmo_hit = active && (rld_q != '0) && (cnt_inc == TMO_W'(rld_q))
                  && !st_commit && !ss_commit;
        cnt_d = cnt_q;
        if (ss_commit) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_inc;
        end
        rld_val = rld_q;
    end

    always_ff @(posedge avm_clk or negedge NRESET) begin
        if (!NRESET) begin
            cnt_q <= '0;
            rld_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rld_val = '0;
`endif

    // A new commit always restarts the handshake; a response commit or timeout ends it.
    always_comb begin
        state_d = state_q;
        if ((state_q == S_PEND) && st_ack0) begin
            state_d = S_BUSY;
        end
        if (active && (st_commit || tmo_hit)) begin
            state_d = S_IDLE;
        end
        if (ss_commit) begin
            state_d = S_PEND;
        end
    end

    always_comb begin
        ss_and = (ss_wr && (ss_idx == 4'd0)) ? ss_din : '1;
        st_clr = (st_wr_start && (st_idx == 5'd4)) ? st_din : '0;
        st_set = (st_wr_start && (st_idx == 5'd3)) ? st_din : '0;
        if (active && st_commit) begin
            st_set[0] = 1'b1;
        end
        hirq_d = ((hirq_q & ss_and) & ~st_clr) | st_set;

        mask_d = (ss_wr && (ss_idx == 4'd1)) ? ss_din : mask_q;
        en_d   = (st_wr_start && (st_idx == 5'd1)) ? st_din[NUM_IRQ-1:0] : en_q;

        pend_set                = '0;
        pend_set[0]             = ss_commit;
        pend_set[1]             = ss_resp_rd;
        pend_set[2]             = tmo_hit;
        pend_set[NUM_IRQ-1:3]   = ext_irq;
        pend_clr = (st_wr_start && (st_idx == 5'd2)) ? st_din[NUM_IRQ-1:0] : '0;
        pend_d   = (pend_q & ~pend_clr) | pend_set;
    end

    always_comb begin
        for (int i = 0; i < NUM_CR; i++) begin
            cr_d[i]   = cr_q[i];
            resp_d[i] = resp_q[i];
            if (ss_wr && ss_in_cr && (ss_cr_off == 4'(i))) begin
                cr_d[i] = ss_din;
            end
            if (st_wr_start && st_in_cr && (st_cr_off == 5'(i))) begin
                resp_d[i] = st_din;
            end
        end
    end

    // Read ports are sampled every cycle, so data seen at a strobe was registered the cycle before.
    always_comb begin
        status                = '0;
        status[NUM_IRQ-1:0]   = pend_q;
        status[DW-1 -: 2]     = state_q;

        ss_dout_d = '0;
        if (ss_idx == 4'd0) begin
            ss_dout_d = hirq_q;
        end else if (ss_idx == 4'd1) begin
            ss_dout_d = mask_q;
        end else if (ss_in_cr) begin
            ss_dout_d = resp_q[ss_cr_off[CRI_W-1:0]];
        end

        st_dout_d = '1;
        case (st_idx)
            5'd0: st_dout_d = status;
            5'd1: begin
                st_dout_d              = '0;
                st_dout_d[NUM_IRQ-1:0] = en_q;
            end
            5'd2: begin
                st_dout_d              = '0;
                st_dout_d[NUM_IRQ-1:0] = pend_q;
            end
            5'd3, 5'd4: st_dout_d = hirq_q;
            5'd5: st_dout_d = rld_val;
            default: begin
                if (st_in_cr) begin
                    st_dout_d = cr_q[st_cr_off[CRI_W-1:0]];
                end
            end
        endcase
    end

    always_ff @(posedge avm_clk or negedge NRESET) begin
        if (!NRESET) begin
            state_q   <= S_IDLE;
            hirq_q    <= HIRQ_RST;
            mask_q    <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            ss_dout_q <= '0;
            st_dout_q <= '0;
            for (int i = 0; i < NUM_CR; i++) begin
                cr_q[i]   <= '0;
                resp_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            hirq_q    <= hirq_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            en_q      <= en_d;
            ss_dout_q <= ss_dout_d;
            st_dout_q <= st_dout_d;
            for (int i = 0; i < NUM_CR; i++) begin
                cr_q[i]   <= cr_d[i];
                resp_q[i] <= resp_d[i];
            end
        end
    end

    assign ss_dout = ss_dout_q;
    assign st_dout = st_dout_q;
    assign ss_irq  = |(hirq_q & mask_q);
    assign st_irq  = |(pend_q & en_q);
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_cdc_mailbox_ctrl.sv
// Bench for cdc_mailbox_ctrl: directed steps plus random traffic checked against a register-level model.
module tb_cdc_mailbox_ctrl;

    localparam int NUM_CR  = 4;
    localparam int DW      = 16;
    localparam int NUM_IRQ = 6;
    localparam int M_IDLE  = 0;
    localparam int M_PEND  = 1;
    localparam int M_BUSY  = 2;

    logic          avm_clk = 1'b0;
    logic          NRESET = 1'b0;
    logic          ss_wr_start = 1'b0, ss_rd_start = 1'b0, ss_cs = 1'b0;
    logic [3:0]    ss_idx = '0;
    logic [15:0]   ss_din = '0;
    logic [15:0]   ss_dout;
    logic          ss_irq;
    logic          st_wr_start = 1'b0;
    logic [4:0]    st_idx = '0;
    logic [15:0]   st_din = '0;
    logic [15:0]   st_dout;
    logic          st_irq;
    logic [2:0]    ext_irq = '0;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int          m_state;
    logic [15:0] m_cr [4];
    logic [15:0] m_resp [4];
    logic [15:0] m_hirq, m_mask, m_rld;
    logic [5:0]  m_pend, m_en;
    logic [15:0] m_ss_dout, m_st_dout;
    int          cyc, entry;
    logic [15:0] hirq_snap;

    always #5 avm_clk = ~avm_clk;

    cdc_mailbox_ctrl #(
        .NUM_CR(NUM_CR), .DW(DW), .NUM_IRQ(NUM_IRQ), .TMO_W(24), .HIRQ_RST(16'h0001)
    ) dut (
        .avm_clk(avm_clk), .NRESET(NRESET),
        .ss_wr_start(ss_wr_start), .ss_rd_start(ss_rd_start), .ss_cs(ss_cs),
        .ss_idx(ss_idx), .ss_din(ss_din), .ss_dout(ss_dout), .ss_irq(ss_irq),
        .st_wr_start(st_wr_start), .st_idx(st_idx), .st_din(st_din),
        .st_dout(st_dout), .st_irq(st_irq), .ext_irq(ext_irq), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_hirq = 16'h0001; m_mask = '0; m_rld = '0;
        m_pend = '0; m_en = '0;
        m_ss_dout = '0; m_st_dout = '0;
        for (int i = 0; i < 4; i++) begin
            m_cr[i] = '0; m_resp[i] = '0;
        end
        cyc = 0; entry = 0;
    endtask

    function automatic logic [15:0] ss_rd_val(input int idx);
        if (idx == 0) return m_hirq;
        if (idx == 1) return m_mask;
        if (idx >= 2 && idx <= 5) return m_resp[idx-2];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] st_rd_val(input int idx);
        case (idx)
            0: return 16'(m_state << 14) | 16'(m_pend);
            1: return 16'(m_en);
            2: return 16'(m_pend);
            3, 4: return m_hirq;
`ifdef CDC_MBX_TIMEOUT_EN
            5: return m_rld;
`else
            5: return 16'h0000;
`endif
            default: begin
                if (idx >= 8 && idx <= 11) return m_cr[idx-8];
                return 16'hFFFF;
            end
        endcase
    endfunction

    task automatic model_step();
        logic        sw, sr, sc, stc, act, fire;
        logic [15:0] and_t, clr_t, set_t;
        logic [5:0]  pset, pclr;
        m_ss_dout = ss_rd_val(int'(ss_idx));
        m_st_dout = st_rd_val(int'(st_idx));
        sw  = ss_wr_start && ss_cs;
        sr  = ss_rd_start && ss_cs;
        sc  = sw && (ss_idx == 4'd5);
        stc = st_wr_start && (st_idx == 5'd11);
        act = (m_state != M_IDLE);
        fire = 1'b0;
`ifdef CDC_MBX_TIMEOUT_EN
        fire = act && (m_rld != 0) && ((cyc - entry) == int'(m_rld)) && !sc && !stc;
`endif
        and_t = (sw && ss_idx == 4'd0) ? ss_din : 16'hFFFF;
        clr_t = (st_wr_start && st_idx == 5'd4) ? st_din : 16'h0000;
        set_t = (st_wr_start && st_idx == 5'd3) ? st_din : 16'h0000;
        if (act && stc) set_t[0] = 1'b1;
        pset = {ext_irq, fire, sr && (ss_idx == 4'd5), sc};
        pclr = (st_wr_start && st_idx == 5'd2) ? st_din[5:0] : 6'd0;

        if (sw && ss_idx == 4'd1) m_mask = ss_din;
        if (sw && ss_idx >= 4'd2 && ss_idx <= 4'd5) m_cr[int'(ss_idx) - 2] = ss_din;
        if (st_wr_start && st_idx == 5'd1) m_en = st_din[5:0];
`ifdef CDC_MBX_TIMEOUT_EN
        if (st_wr_start && st_idx == 5'd5) m_rld = st_din;
`endif
        if (st_wr_start && st_idx >= 5'd8 && st_idx <= 5'd11) m_resp[int'(st_idx) - 8] = st_din;

        if (sc) begin
            m_state = M_PEND;
            entry = cyc;
        end else if (act && (stc || fire)) begin
            m_state = M_IDLE;
        end else if (m_state == M_PEND && pclr[0]) begin
            m_state = M_BUSY;
        end
        m_hirq = ((m_hirq & and_t) & ~clr_t) | set_t;
        m_pend = (m_pend & ~pclr) | pset;
        cyc++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_busy"},    busy,    (m_state != M_IDLE));
        chk({tag, "_ss_irq"},  ss_irq,  |(m_hirq & m_mask));
        chk({tag, "_st_irq"},  st_irq,  |(m_pend & m_en));
        chk({tag, "_ss_dout"}, ss_dout, m_ss_dout);
        chk({tag, "_st_dout"}, st_dout, m_st_dout);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge avm_clk);
        #1;
        check_all(tag);
        ss_wr_start = 1'b0; ss_rd_start = 1'b0; st_wr_start = 1'b0; ext_irq = '0;
    endtask

    task automatic ss_write(input logic [3:0] idx, input logic [15:0] d);
        ss_cs = 1'b1; ss_wr_start = 1'b1; ss_idx = idx; ss_din = d;
        tick("ss_wr");
    endtask

    task automatic st_write(input logic [4:0] idx, input logic [15:0] d);
        st_wr_start = 1'b1; st_idx = idx; st_din = d;
        tick("st_wr");
    endtask

    initial begin
        logic [15:0] cr_vals [4];
        cr_vals[0] = 16'h1111; cr_vals[1] = 16'h2222; cr_vals[2] = 16'h3333; cr_vals[3] = 16'h4444;
        model_reset();

        // 1: reset values
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ss_irq", ss_irq, 1'b0);
        chk("rst_st_irq", st_irq, 1'b0);
        chk("rst_ss_dout", ss_dout, 16'h0000);
        chk("rst_st_dout", st_dout, 16'h0000);
        NRESET = 1'b1;
        @(posedge avm_clk); #1;
        st_idx = 5'd0; ss_idx = 4'd0;
        tick("t1");
        chk("t1_status", st_dout, 16'h0000);
        chk("t1_hirq", ss_dout, 16'h0001);

        // 2: command handshake
        st_write(5'd4, 16'hFFFF);
        st_write(5'd1, 16'h0001);
        for (int i = 0; i < 4; i++) ss_write(4'(2 + i), cr_vals[i]);
        chk("t2_st_irq", st_irq, 1'b1);
        chk("t2_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            st_idx = 5'(8 + i);
            tick("t2_rd");
            chk("t2_cr", st_dout, cr_vals[i]);
        end
        st_write(5'd2, 16'h0001);
        st_idx = 5'd0;
        tick("t2_st");
        chk("t2_status_busy", st_dout, 16'h8000);
        st_write(5'd11, 16'hBEEF);
        chk("t2_idle", busy, 1'b0);
        ss_idx = 4'd0;
        tick("t2_h");
        chk("t2_cmok", ss_dout, 16'h0001);

        // 3: same-cycle HIRQ merge
        ss_write(4'd1, 16'h0001);
        st_write(5'd4, 16'hFFFF);
        st_write(5'd3, 16'h0001);
        ss_cs = 1'b1; ss_wr_start = 1'b1; ss_idx = 4'd0; ss_din = 16'hFFFE;
        st_wr_start = 1'b1; st_idx = 5'd3; st_din = 16'h0004;
        tick("t3");
        chk("t3_ss_irq", ss_irq, 1'b0);
        ss_idx = 4'd0;
        tick("t3_rd");
        chk("t3_hirq", ss_dout, 16'h0004);

        // 4: timeout
        st_write(5'd2, 16'h003F);
`ifdef CDC_MBX_TIMEOUT_EN
        st_write(5'd5, 16'd10);
        st_write(5'd1, 16'h0004);
        hirq_snap = m_hirq;
        ss_write(4'd5, 16'hA5A5);
        repeat (9) tick("t4_wait");
        chk("t4_early_irq", st_irq, 1'b0);
        chk("t4_early_busy", busy, 1'b1);
        tick("t4_hit");
        chk("t4_tmo_irq", st_irq, 1'b1);
        chk("t4_tmo_idle", busy, 1'b0);
        ss_idx = 4'd0;
        tick("t4_rd");
        chk("t4_hirq_kept", ss_dout, hirq_snap);
        st_write(5'd5, 16'd0);
`else
        ss_write(4'd5, 16'hA5A5);
        repeat (1000) tick("t4_wait");
        chk("t4_still_busy", busy, 1'b1);
        st_idx = 5'd0;
        tick("t4_st");
        chk("t4_still_pend", st_dout[15:14], 2'd1);
        st_write(5'd11, 16'h0000);
`endif

        // 5: external source vs same-cycle W1C
        st_write(5'd2, 16'h003F);
        ext_irq = 3'b001;
        tick("t5_set");
        ext_irq = 3'b001; st_wr_start = 1'b1; st_idx = 5'd2; st_din = 16'h0008;
        tick("t5_race");
        st_idx = 5'd0;
        tick("t5_rd");
        chk("t5_pend3", st_dout[3], 1'b1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            ss_cs       = ($urandom_range(0, 3) != 0);
            ss_wr_start = ($urandom_range(0, 3) == 0);
            ss_rd_start = !ss_wr_start && ($urandom_range(0, 3) == 0);
            ss_idx      = 4'($urandom_range(0, 15));
            ss_din      = 16'($urandom_range(0, 65535));
            st_wr_start = ($urandom_range(0, 2) == 0);
            st_idx      = 5'($urandom_range(0, 15));
            st_din      = 16'($urandom_range(0, 65535));
            if (st_idx == 5'd5) st_din = 16'($urandom_range(0, 40));
            ext_irq     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            tick("rnd");
        end

        // 6: asynchronous reset while BUSY
        st_write(5'd2, 16'h003F);
        ss_write(4'd5, 16'h5555);
        st_write(5'd2, 16'h0001);
        ss_write(4'd1, 16'h0001);
        st_write(5'd3, 16'h0001);
        chk("t6_pre_busy", busy, 1'b1);
        chk("t6_pre_ss_irq", ss_irq, 1'b1);
        #2;
        NRESET = 1'b0;
        #1;
        chk("t6_async_busy", busy, 1'b0);
        chk("t6_async_ss_irq", ss_irq, 1'b0);
        chk("t6_async_ss_dout", ss_dout, 16'h0000);
        chk("t6_async_st_dout", st_dout, 16'h0000);
        model_reset();
        #2;
        NRESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_idx = 5'(8 + i);
            tick("t6_rd");
            chk("t6_cr_zero", st_dout, 16'h0000);
        end
        ss_idx = 4'd0;
        tick("t6_h");
        chk("t6_hirq_rst", ss_dout, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_mailbox_ctrl.md
Name: cdc_mailbox_ctrl

Overview:
Parametrised Saturn-CDC to STM32 mailbox and interrupt controller.
- Holds NUM_CR command registers written by Saturn and NUM_CR response registers written by STM32.
- Holds the HIRQ/mask pair and a command-handshake FSM with timeout.
- Holds a generalised STM32 interrupt block: latched sources, enables, write-1-to-clear acknowledge.
- Sits between the already-synchronised ABUS/FSMC strobe logic and the top-level pins, all in the avm_clk domain.

Parameters:
NUM_CR, 4, number of CR/RESP register pairs (legal 2..8); the last index is the "commit" register.
DW, 16, data width of all registers.
NUM_IRQ, 6, number of STM32 interrupt sources (legal 4..16); sources 3..NUM_IRQ-1 are external.
TMO_W, 24, width of the command timeout counter.
HIRQ_RST, 16'h0001, reset value of HIRQ.

Ports:
avm_clk  in  1  system clock
NRESET  in  1  asynchronous active-low reset
ss_wr_start  in  1  one-cycle Saturn write strobe (already synchronised)
ss_rd_start  in  1  one-cycle Saturn read strobe
ss_cs  in  1  Saturn CDC window select, qualifies both strobes
ss_idx  in  4  Saturn word index
ss_din  in  DW  Saturn write data
ss_dout  out  DW  Saturn read data, registered
ss_irq  out  1  (HIRQ & mask) != 0
st_wr_start  in  1  one-cycle STM32 write strobe
st_idx  in  5  STM32 word index
st_din  in  DW  STM32 write data
st_dout  out  DW  STM32 read data, registered
st_irq  out  1  OR of enabled pending sources
ext_irq  in  NUM_IRQ-3  external one-cycle source pulses
busy  out  1  FSM not IDLE

Behaviour:
Reset: all outputs 0, all registers 0, HIRQ=HIRQ_RST, FSM=IDLE.

Saturn map (ss_idx):
- 0: HIRQ; write = AND with ss_din.
- 1: HIRQ mask.
- 2+i: write CR[i], read RESP[i], for i < NUM_CR.
- Other indices: read 0, writes ignored.

STM32 map (st_idx):
- 0: status = {state[1:0], zero pad, pend[NUM_IRQ-1:0]}.
- 1: irq enable.
- 2: W1C acknowledge of pend.
- 3: HIRQ set (OR).
- 4: HIRQ clear (AND NOT).
- 5: timeout reload, low DW bits of TMO_W.
- 8+i: write RESP[i], read CR[i].
- Index 5 reads back the reload value; undefined indices read 16'hFFFF.

Read timing:
- ss_dout and st_dout update every clock from the current index, giving 1-cycle latency.
- The value seen at a strobe is the one registered the cycle before.

HIRQ same-cycle merge: next = ((HIRQ & ss_and_term) & ~st_clr_term) | st_set_term. Set wins. Each unused term is neutral.

pend[k]:
- Set by its event, cleared by W1C.
- Set wins over a same-cycle clear.
- Sources: pend[0] = Saturn write of CR[NUM_CR-1]; pend[1] = Saturn read of RESP[NUM_CR-1]; pend[2] = timeout; pend[3+j] = ext_irq[j].
- st_irq = |(pend & enable).

FSM states: IDLE, PEND, BUSY.
- IDLE -> PEND on Saturn commit write (CR[NUM_CR-1]).
- PEND -> BUSY on STM32 W1C of pend[0].
- PEND or BUSY -> IDLE on STM32 write of RESP[NUM_CR-1]; the same cycle sets HIRQ[0] (CMOK).
- A commit write while not IDLE still updates CR and pend[0], and the FSM restarts in PEND with the counter cleared.

Timeout counter (TMO_W bits):
- Clears on entry to PEND and counts each cycle in PEND or BUSY.
- When it equals the reload value (zero-extended) and reload != 0: set pend[2], go to IDLE, leave HIRQ unchanged.
- reload == 0 disables the timeout.
- It saturates and never wraps.
- A RESP commit and a timeout in the same cycle: the RESP commit wins and pend[2] is not set.

Reset asserted mid-command returns everything to its reset values immediately, asynchronously.

Optional Feature:
Macro CDC_MBX_TIMEOUT_EN.
- Defined: timeout counter, index 5 register, and pend[2] behave as above.
- Undefined: no counter logic; index 5 reads 0 and ignores writes; pend[2] is tied 0; the FSM leaves PEND/BUSY only by RESP commit or a new commit.

Test Plan:
1. Reset, then read STM32 idx0 and Saturn idx0 -> status 16'h0000, HIRQ 16'h0001; ss_irq=0, st_irq=0, busy=0.
2. Write enable=1; Saturn writes CR0..CR3 = 1111/2222/3333/4444 -> pend[0] and st_irq set after the CR3 strobe, busy=1, STM32 idx 8..11 read those values. W1C 1 -> state BUSY. Write RESP3 -> IDLE, HIRQ[0]=1.
3. Mask=1, HIRQ=1: Saturn writes 16'hFFFE to idx0 in the same cycle STM32 writes 16'h0004 to idx3 -> HIRQ=16'h0004, ss_irq=0.
4. Timeout reload=10, commit, no response -> pend[2] set exactly 10 cycles after PEND entry, state IDLE, HIRQ unchanged. With the macro undefined -> still PEND after 1000 cycles.
5. ext_irq[0] pulse in the same cycle as a W1C of bit3 -> pend[3] remains 1.
6. Assert NRESET low while in BUSY -> busy=0, CRs=0, HIRQ=16'h0001 without waiting for a clock edge.
